// File: rtl/wb_sram8_bridge.sv
// Wishbone (16-bit, byte-select) slave to 8-bit asynchronous SRAM bridge.
// Each selected byte runs SETUP -> STROBE(WAIT_CYCLES+1) -> HOLD, low byte first.
module wb_sram8_bridge #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MEM_WORDS   = 24'h100000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [23:0] wb_adr,
    input  logic [1:0]  wb_sel,
    input  logic [15:0] wb_i_dat,
    output logic [15:0] wb_o_dat,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        wb_rty,
    output logic [24:0] sram_addr,
    output logic [7:0]  sram_dq_o,
    input  logic [7:0]  sram_dq_i,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    state_t      r_state;
    logic [23:0] r_adr;
    logic        r_we;
    logic        r_sel_hi;   // high byte requested
    logic [7:0]  r_dat_hi;   // high write byte, driven on the second access
    logic        r_hi;       // current access targets the high byte
    logic [3:0]  r_cnt;
    logic        r_abort;    // wb_cyc dropped during this access

    logic w_req, w_oob, w_last, w_more, w_abort;

    assign w_req   = wb_cyc & wb_stb;
    assign w_oob   = {8'd0, wb_adr} >= MEM_WORDS;
    assign w_last  = (r_cnt == 4'(WAIT_CYCLES));
    assign w_more  = !r_hi && r_sel_hi;
    assign w_abort = r_abort | ~wb_cyc;
    assign wb_rty  = 1'b0;

    // Single FSM; every output is registered and changes with the state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_adr      <= '0;
            r_we       <= 1'b0;
            r_sel_hi   <= 1'b0;
            r_dat_hi   <= '0;
            r_hi       <= 1'b0;
            r_cnt      <= '0;
            r_abort    <= 1'b0;
            wb_o_dat   <= '0;
            wb_ack     <= 1'b0;
            wb_err     <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    wb_ack <= 1'b0;
                    wb_err <= 1'b0;
                    if (w_req) begin
                        r_adr    <= wb_adr;
                        r_we     <= wb_we;
                        r_sel_hi <= wb_sel[1];
                        r_dat_hi <= wb_i_dat[15:8];
                        r_abort  <= 1'b0;
                        // Unselected bytes of a read must come back as zero.
                        if (!wb_we) wb_o_dat <= '0;
                        if (w_oob) begin
                            r_state <= RESP;
                            wb_err  <= 1'b1;
                        end else if (wb_sel == 2'b00) begin
                            r_state <= RESP;
                            wb_ack  <= 1'b1;
                        end else begin
                            r_state    <= SETUP;
                            r_hi       <= ~wb_sel[0];
                            sram_addr  <= {wb_adr, ~wb_sel[0]};
                            sram_dq_o  <= wb_sel[0] ? wb_i_dat[7:0] : wb_i_dat[15:8];
                            sram_dq_oe <= wb_we;
                            sram_ce_n  <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    r_state   <= STROBE;
                    r_cnt     <= '0;
                    r_abort   <= w_abort;
                    sram_oe_n <= r_we;
                    sram_we_n <= ~r_we;
                end
                STROBE: begin
                    r_abort <= w_abort;
                    if (w_last) begin
                        r_state   <= HOLD;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        if (!r_we) begin
                            if (r_hi) wb_o_dat[15:8] <= sram_dq_i;
                            else      wb_o_dat[7:0]  <= sram_dq_i;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                HOLD: begin
                    if (!w_abort && w_more) begin
                        r_state   <= SETUP;
                        r_hi      <= 1'b1;
                        sram_addr <= {r_adr, 1'b1};
                        sram_dq_o <= r_dat_hi;
                    end else begin
                        // Abandoned bus cycle returns straight to IDLE without a response.
                        r_state    <= w_abort ? IDLE : RESP;
                        wb_ack     <= ~w_abort;
                        sram_ce_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    wb_ack  <= 1'b0;
                    wb_err  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
